// File: rtl/sound_sequencer.sv
// Game sound sequencer: arbitrates dot/fruit/ghost/death requests and plays a 4-note melody each.
// Define SOUND_PREEMPT_EN to let a death request abort any other melody in progress.
module sound_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int NOTE_TICKS = 120,
  parameter int GAP_TICKS  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic       busy,
  output logic       done,
  output logic [1:0] tone_num,
  output logic       tone_pressed,
  output logic       audio_en
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] NOTE_LAST  = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sound_reg, sound_next;
  logic [1:0]    note_reg, note_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [3:0]    pending_reg, pending_next;
  logic [3:0]    ack_reg, ack_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic [1:0]    tone_num_reg, tone_num_next;
  logic          tone_pressed_reg, tone_pressed_next;
  logic          audio_en_reg, audio_en_next;
  logic          tick;
  logic          abort;
  logic          sounding;
  logic [2:0]    mel;

  // Melody ROM entry: {rest, num}
  function automatic logic [2:0] melody(input logic [1:0] snd, input logic [1:0] idx);
    case ({snd, idx})
      4'h0: melody = 3'b000;  4'h1: melody = 3'b001;  4'h2: melody = 3'b000;  4'h3: melody = 3'b001;
      4'h4: melody = 3'b010;  4'h5: melody = 3'b001;  4'h6: melody = 3'b000;  4'h7: melody = 3'b100;
      4'h8: melody = 3'b000;  4'h9: melody = 3'b000;  4'hA: melody = 3'b010;  4'hB: melody = 3'b010;
      default: melody = 3'(3 - int'(idx));
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      sound_reg        <= '0;
      note_reg         <= '0;
      presc_reg        <= '0;
      tick_reg         <= '0;
      pending_reg      <= '0;
      ack_reg          <= '0;
      done_reg         <= 1'b0;
      busy_reg         <= 1'b0;
      tone_num_reg     <= '0;
      tone_pressed_reg <= 1'b0;
      audio_en_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sound_reg        <= sound_next;
      note_reg         <= note_next;
      presc_reg        <= presc_next;
      tick_reg         <= tick_next;
      pending_reg      <= pending_next;
      ack_reg          <= ack_next;
      done_reg         <= done_next;
      busy_reg         <= busy_next;
      tone_num_reg     <= tone_num_next;
      tone_pressed_reg <= tone_pressed_next;
      audio_en_reg     <= audio_en_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sound_next   = sound_reg;
    note_next    = note_reg;
    presc_next   = presc_reg;
    tick_next    = tick_reg;
    ack_next     = '0;
    done_next    = 1'b0;
    pending_next = (pending_reg & ~ack_reg) | req;
    tick         = (presc_reg == PRESC_LAST);

`ifdef SOUND_PREEMPT_EN
    abort = (state_reg != IDLE) && (sound_reg != 2'd3) && pending_next[3];
`else
    abort = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next = PLAY;
          note_next  = '0;
          presc_next = '0;
          tick_next  = '0;
          if (pending_reg[3])      sound_next = 2'd3;
          else if (pending_reg[2]) sound_next = 2'd2;
          else if (pending_reg[1]) sound_next = 2'd1;
          else                     sound_next = 2'd0;
          ack_next = 4'b0001 << sound_next;
        end
      end
      PLAY: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          if (tick_reg == NOTE_LAST) begin
            state_next = GAP;
            tick_next  = '0;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      GAP: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          tick_next = tick_reg + 1'b1;
          if (tick_reg == GAP_LAST) begin
            tick_next = '0;
            if (note_reg == 2'd3) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = PLAY;
              note_next  = note_reg + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A preempted melody simply stops; the death request is picked up by IDLE arbitration.
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
      presc_next = '0;
      tick_next  = '0;
    end

    // Outputs are computed from the next state so they line up with it after the register.
    mel               = melody(sound_next, note_next);
    sounding          = (state_next == PLAY) && !mel[2];
    tone_num_next     = sounding ? mel[1:0] : 2'd0;
    tone_pressed_next = sounding;
    audio_en_next     = sounding;
    busy_next         = (state_next != IDLE);
  end

  assign ack          = ack_reg;
  assign done         = done_reg;
  assign busy         = busy_reg;
  assign tone_num     = tone_num_reg;
  assign tone_pressed = tone_pressed_reg;
  assign audio_en     = audio_en_reg;

endmodule
